// File: rtl/count_period_capture_pkg.sv
// Shared types for the count period capture block: capture FSM encoding
// and record layout constants.
package count_capture_pkg;

    localparam logic [0:0] IDLE_ENC  = 1'b0;
    localparam logic [0:0] ARMED_ENC = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = IDLE_ENC,
        ARMED = ARMED_ENC
    } cap_state_e;

    // A record is {stamp, delta}, each WIDTH bits, stamp in the upper half.
    localparam int unsigned REC_FIELDS = 2;

endpackage

// File: rtl/count_period_capture_fifo.sv
// First-word-fall-through synchronous FIFO with explicit occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft
    import count_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign head_data = mem[rd_ptr];

    // When full, wr_ptr == rd_ptr, so a push+pop overwrites the slot being popped.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/count_period_capture.sv
// Timestamps rising edges of trig against an upstream count and queues
// {stamp, delta-since-previous-event} records for a valid/ready consumer.
module count_period_capture
    import count_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           count,
    input  logic                       trig,
    input  logic                       clr_ovf,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_stamp,
    output logic [WIDTH-1:0]           m_delta,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf
);

    localparam int unsigned REC_W = REC_FIELDS * WIDTH;

    cap_state_e       state;
    logic             trig_q;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] delta;
    logic             evt;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    logic [REC_W-1:0] head;

    always_comb begin
        evt   = trig & ~trig_q;
        delta = count - prev;
        push  = evt & (state == ARMED);
        pop   = m_valid & m_ready;
        drop  = push & full & ~pop;
    end

    // trig_q resets high so a trig held through reset release is not an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_q <= 1'b1;
            state  <= IDLE;
            prev   <= '0;
            ovf    <= 1'b0;
        end else begin
            trig_q <= trig;
            if (evt) begin
                prev  <= count;
                state <= ARMED;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({count, delta}),
        .pop       (pop),
        .head_data (head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign m_valid = ~empty;
    assign m_stamp = head[REC_W-1:WIDTH];
    assign m_delta = head[WIDTH-1:0];

endmodule

// File: tb/tb_count_period_capture.sv
// Directed bench for count_period_capture (WIDTH=8, DEPTH=4): arming, wrap,
// overflow/drop, full+pop, ovf set-vs-clear priority and mid-run reset.
module tb_count_period_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] count;
    logic       trig;
    logic       clr_ovf;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_stamp;
    logic [7:0] m_delta;
    logic [2:0] level;
    logic       ovf;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    count_period_capture #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .count   (count),
        .trig    (trig),
        .clr_ovf (clr_ovf),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_stamp (m_stamp),
        .m_delta (m_delta),
        .level   (level),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input logic [7:0] s, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(m_valid), 32'd1);
        chk({tag, ".stamp"}, 32'(m_stamp), 32'(s));
        chk({tag, ".delta"}, 32'(m_delta), 32'(d));
    endtask

    // Leaves trig low afterwards; caller must tick before the next ev.
    task automatic ev(input logic [7:0] c);
        count = c;
        trig  = 1'b1;
        tick();
        trig  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_s [4];
        logic [7:0] exp_d [4];

        rst_n = 1'b0; trig = 1'b1; count = '0; clr_ovf = 1'b0; m_ready = 1'b0;
        tick(); tick();
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.valid", 32'(m_valid), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.stamp", 32'(m_stamp), 32'd0);
        chk("rst.delta", 32'(m_delta), 32'd0);

        // trig held high through reset release: no event
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("held.level", 32'(level), 32'd0);
        chk("held.valid", 32'(m_valid), 32'd0);

        // Arming, in-order records, wrap-around delta
        m_ready = 1'b1;
        trig = 1'b0; tick();
        ev(8'd10);
        chk("arm.valid", 32'(m_valid), 32'd0);
        tick();
        ev(8'd25);
        chk_rec("r25", 8'd25, 8'd15);
        chk("r25.level", 32'(level), 32'd1);
        tick();
        chk("r25.popped", 32'(m_valid), 32'd0);
        ev(8'd250);
        chk_rec("r250", 8'd250, 8'd225);
        tick();
        ev(8'd4);
        chk_rec("rwrap", 8'd4, 8'd10);
        tick();
        chk("wrap.popped", 32'(m_valid), 32'd0);

        // Fresh start, fill to full, drop fifth record
        m_ready = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        ev(8'd0); tick();
        ev(8'd1); tick();
        ev(8'd3); tick();
        ev(8'd6); tick();
        ev(8'd10);
        chk("fill.level", 32'(level), 32'd4);
        chk("fill.ovf", 32'(ovf), 32'd0);
        tick();
        ev(8'd15);
        chk("drop.level", 32'(level), 32'd4);
        chk("drop.ovf", 32'(ovf), 32'd1);
        chk_rec("drop.head", 8'd1, 8'd1);
        tick();
        exp_s = '{8'd1, 8'd3, 8'd6, 8'd10};
        exp_d = '{8'd1, 8'd2, 8'd3, 8'd4};
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_rec("drain1", exp_s[i], exp_d[i]);
            tick();
        end
        chk("drain1.empty", 32'(m_valid), 32'd0);
        chk("drain1.ovf", 32'(ovf), 32'd1);
        ev(8'd20);
        chk_rec("after_drop", 8'd20, 8'd5);
        tick();
        m_ready = 1'b0;

        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        chk("clr.ovf", 32'(ovf), 32'd0);

        // Full FIFO, event coinciding with a pop
        ev(8'd30); tick();
        ev(8'd40); tick();
        ev(8'd50); tick();
        ev(8'd60);
        chk("full.level", 32'(level), 32'd4);
        chk_rec("full.head", 8'd30, 8'd10);
        tick();
        count = 8'd75; trig = 1'b1; m_ready = 1'b1;
        tick();
        trig = 1'b0; m_ready = 1'b0;
        chk("fullpop.level", 32'(level), 32'd4);
        chk("fullpop.ovf", 32'(ovf), 32'd0);
        chk_rec("fullpop.head", 8'd40, 8'd10);
        tick();

        // Drop and clr_ovf in the same cycle: set wins
        count = 8'd80; trig = 1'b1; clr_ovf = 1'b1;
        tick();
        trig = 1'b0;
        chk("setwins.ovf", 32'(ovf), 32'd1);
        chk("setwins.level", 32'(level), 32'd4);
        tick();
        clr_ovf = 1'b0;
        chk("clralone.ovf", 32'(ovf), 32'd0);
        exp_s = '{8'd40, 8'd50, 8'd60, 8'd75};
        exp_d = '{8'd10, 8'd10, 8'd10, 8'd15};
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_rec("drain2", exp_s[i], exp_d[i]);
            tick();
        end
        m_ready = 1'b0;
        chk("drain2.empty", 32'(m_valid), 32'd0);

        // Mid-run reset with records queued
        ev(8'd90); tick();
        ev(8'd95); tick();
        ev(8'd100);
        chk("pre_rst.level", 32'(level), 32'd3);
        chk_rec("pre_rst.head", 8'd90, 8'd10);
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst.level", 32'(level), 32'd0);
        chk("midrst.valid", 32'(m_valid), 32'd0);
        chk("midrst.ovf", 32'(ovf), 32'd0);
        chk("midrst.stamp", 32'(m_stamp), 32'd0);
        chk("midrst.delta", 32'(m_delta), 32'd0);
        tick();
        ev(8'd110);
        chk("rearm.valid", 32'(m_valid), 32'd0);
        tick();
        ev(8'd117);
        chk_rec("rearm.rec", 8'd117, 8'd7);
        chk("rearm.level", 32'(level), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
